serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial, LSB-first adder: the additive counterpart to the team's subtractor cells. It accepts two WIDTH-bit operands and a carry-in on a start pulse and computes one sum bit per clock with a single full-adder slice and a carry flip-flop. It presents the WIDTH-bit sum and carry-out with a one-cycle done strobe. It sits in area-constrained datapaths where latency is traded for a single adder slice.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 1..32

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when busy=0
- a  input  WIDTH  addend, sampled on the accepted start cycle
- b  input  WIDTH  addend, sampled on the accepted start cycle
- cin  input  1  carry-in, sampled on the accepted start cycle
- busy  output  1  high while the operation is in progress (RUN state)
- done  output  1  one-cycle strobe; sum/cout valid from this cycle onward
- sum  output  WIDTH  registered result, a+b+cin mod 2^WIDTH
- cout  output  1  registered carry-out, bit WIDTH of a+b+cin

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: WIDTH bit-cycles of addition.
  - DONE: single cycle, done=1.
- IDLE or DONE with start=1 → RUN:
  - load shift registers sa<=a and sb<=b.
  - carry<=cin, count<=0, partial<=0.
- IDLE or DONE with start=0 → IDLE.
- RUN, each cycle:
  - s = sa[0]^sb[0]^carry; carry <= maj(sa[0],sb[0],carry).
  - sa and sb shift right by 1.
  - partial shifts right with s inserted at the MSB; count <= count+1.
- RUN, when count = WIDTH-1:
  - sum <= {s, partial[WIDTH-1:1]} (the final partial), cout <= the final carry.
  - next state DONE.
- start while in RUN is ignored: no effect on operands, count, or result.
- sum/cout change only on the RUN→DONE transition and hold until the next completion. Intermediate shift state is never visible on sum.
- busy = (state==RUN). done = (state==DONE). Both are decoded from the state register, with no combinational path from any input.
- Counter width is clog2(WIDTH+1) and never wraps during RUN. WIDTH=1 completes in a single RUN cycle.
- Reset, at any time including mid-RUN:
  - state IDLE, busy=0, done=0, sum=0, cout=0.
  - carry, count, sa, sb and partial cleared.
  - The in-flight operation is discarded and no done is produced for it.
- rst has priority over start in the same cycle.

## Timing
- Accepted start at edge 0 → busy=1 after edge 0 for exactly WIDTH cycles.
- done=1 for the cycle after edge WIDTH; sum/cout are valid in that same cycle.
- Latency from start to done is WIDTH+1 cycles. Throughput is one operation per WIDTH+1 cycles, because start is accepted in the DONE cycle.
- Outputs are fully registered.
- Inputs a, b and cin are don't-care except on the accepted start cycle.
- After rst deasserts, the first start is accepted on the next edge.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0 → busy high 8 cycles; done in cycle 9; sum=0x96, cout=0.
- WIDTH=8, a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Start pulsed again at cycle 3 of a RUN with different operands → ignored. The original result is delivered at cycle 9, followed by exactly one done.
- Start asserted in the DONE cycle with a=0x01, b=0x02 → busy the next cycle; the prior sum is held until the new done shows sum=0x03, cout=0.
- rst at cycle 4 of RUN → next cycle busy=0, done=0, sum=0x00, cout=0. No done appears afterward until a new start.
- WIDTH=1, a=1, b=1, cin=1 → done 2 cycles after start; sum=1, cout=1. Also run 1000 random 8-bit operands against a+b+cin.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder slice plus a carry flop, producing
// a WIDTH-bit sum and carry-out after WIDTH run cycles, flagged by a done strobe.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   sa;
    logic [WIDTH-1:0]   sb;
    logic [WIDTH-1:0]   partial;
    logic [WIDTH-1:0]   partial_next;
    logic [CNT_W-1:0]   count;
    logic               carry;
    logic               carry_next;
    logic               s;
    logic               last;

    assign s          = sa[0] ^ sb[0] ^ carry;
    assign carry_next = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
    assign last       = (count == CNT_W'(WIDTH - 1));

    // A 1-bit result has no upper partial bits to shift down.
    generate
        if (WIDTH == 1) begin : g_one
            assign partial_next = s;
        end else begin : g_multi
            assign partial_next = {s, partial[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN:     state_next = last ? DONE : RUN;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sa      <= '0;
            sb      <= '0;
            partial <= '0;
            count   <= '0;
            carry   <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sa      <= a;
                        sb      <= b;
                        carry   <= cin;
                        count   <= '0;
                        partial <= '0;
                    end
                end
                RUN: begin
                    sa      <= sa >> 1;
                    sb      <= sb >> 1;
                    carry   <= carry_next;
                    partial <= partial_next;
                    count   <= count + CNT_W'(1);
                    // Result registers update only on completion, so shift state never leaks out.
                    if (last) begin
                        sum  <= partial_next;
                        cout <= carry_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1; expected sums are
// queued when a start is accepted and compared whenever done is seen.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int checks = 0;
    int errors = 0;
    int dn8 = 0;
    int dn1 = 0;
    logic [8:0] q8[$];
    logic [1:0] q1[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            dn8++;
            if (q8.size() == 0) chk("spurious_done8", 64'(done8), 64'd0);
            else chk("sum8", 64'({cout8, sum8}), 64'(q8.pop_front()));
        end
        if (done1 === 1'b1) begin
            dn1++;
            if (q1.size() == 0) chk("spurious_done1", 64'(done1), 64'd0);
            else chk("sum1", 64'({cout1, sum1}), 64'(q1.pop_front()));
        end
    end

    // Launch one 8-bit op and wait (bounded) for its done; returns at the done cycle.
    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int lat;
        start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
        q8.push_back({1'b0, a} + {1'b0, b} + 9'(c));
        step();
        start8 = 1'b0; a8 = $urandom; b8 = $urandom; cin8 = $urandom;
        lat = 1;
        while (done8 !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        chk("lat8", 64'(lat), 64'd9);
    endtask

    initial begin
        logic [8:0] held;
        int         d0;
        rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
        a8 = 8'h0; b8 = 8'h0; cin8 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_busy", 64'(busy8), 64'd0);
        chk("rst_done", 64'(done8), 64'd0);
        chk("rst_sum",  64'({cout8, sum8}), 64'd0);

        // Basic op with per-cycle busy tracking
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0;
        q8.push_back(9'h096);
        step();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("busy_run", 64'({busy8, done8}), 64'b10);
            step();
        end
        chk("done_cycle9", 64'({busy8, done8}), 64'b01);
        chk("sum_5a3c", 64'({cout8, sum8}), 64'h096);
        step();
        chk("done_one_cycle", 64'(done8), 64'd0);

        go8(8'hFF, 8'h01, 1'b0);
        chk("sum_ff01", 64'({cout8, sum8}), 64'h100);
        go8(8'hFF, 8'hFF, 1'b1);
        chk("sum_ffff1", 64'({cout8, sum8}), 64'h1FF);

        // Start in DONE: accepted, previous result held until new done
        held = {cout8, sum8};
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
        q8.push_back(9'h003);
        step();
        start8 = 1'b0;
        chk("busy_after_done_start", 64'(busy8), 64'd1);
        for (int i = 0; i < 7; i++) begin
            chk("sum_held", 64'({cout8, sum8}), 64'(held));
            step();
        end
        step();
        chk("done_0102", 64'(done8), 64'd1);
        chk("sum_0102", 64'({cout8, sum8}), 64'h003);
        step(); step();

        // Start during RUN is ignored
        d0 = dn8;
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1;
        q8.push_back(9'h047);
        step();
        start8 = 1'b0;
        step(); step();
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'hCC; cin8 = 1'b1;
        step();
        start8 = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("done_orig", 64'({done8, cout8, sum8}), 64'h247);
        for (int i = 0; i < 15; i++) step();
        chk("one_done_only", 64'(dn8 - d0), 64'd1);

        // Reset mid-RUN discards the operation
        d0 = dn8;
        start8 = 1'b1; a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0;
        q8.push_back(9'h088);
        step();
        start8 = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        void'(q8.pop_back());
        chk("midrst_flags", 64'({busy8, done8}), 64'd0);
        chk("midrst_sum", 64'({cout8, sum8}), 64'd0);
        for (int i = 0; i < 15; i++) step();
        chk("no_done_after_rst", 64'(dn8 - d0), 64'd0);

        // WIDTH=1 operation
        start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        q1.push_back(2'b11);
        step();
        start1 = 1'b0;
        chk("w1_busy", 64'({busy1, done1}), 64'b10);
        step();
        chk("w1_done", 64'({busy1, done1, cout1, sum1}), 64'b0111);
        for (int i = 0; i < 4; i++) begin
            logic [0:0] ra, rb;
            logic       rc;
            ra = 1'($urandom); rb = 1'($urandom); rc = 1'($urandom);
            start1 = 1'b1; a1 = ra; b1 = rb; cin1 = rc;
            q1.push_back(2'(ra) + 2'(rb) + 2'(rc));
            step();
            start1 = 1'b0;
            step();
            chk("w1_rand_done", 64'(done1), 64'd1);
        end
        step();

        // Back-to-back random ops, each started in the prior DONE cycle
        for (int i = 0; i < 1000; i++) begin
            go8(8'($urandom), 8'($urandom), 1'($urandom));
        end
        step(); step(); step();
        chk("q8_drained", 64'(q8.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
